dma_axi_slave_mem: RTL and testbench
====================================

# dma_axi_slave_mem

Synthesizable AXI3 64-bit slave memory attached directly downstream of the DMA controller's AXI master port 0 (AW/W/B/AR/R channel 0). It accepts the controller's INCR read and write bursts, stores data in an internal word array, and returns B and R responses with deterministic timing. The bench uses it as the source and destination memory for DMA transfers, and the AXI monitor observes the same pins.

## Interface
- ADDR_W, 32, byte address width of awaddr/araddr
- ID_W, 4, width of the id fields
- DEPTH, 1024, memory depth in 64-bit words (power of two)
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- awid/awaddr/awlen/awsize  input  ID_W/ADDR_W/4/2  write address; awlen is beats-1; awsize is log2 bytes per beat
- awvalid input 1; awready output 1  AW handshake
- wid/wdata/wstrb/wlast  input  ID_W/64/8/1  write data beat
- wvalid input 1; wready output 1  W handshake
- bid/bresp  output  ID_W/2  write response
- bvalid output 1; bready input 1  B handshake
- arid/araddr/arlen/arsize  input  ID_W/ADDR_W/4/2  read address
- arvalid input 1; arready output 1  AR handshake
- rid/rdata/rresp/rlast  output  ID_W/64/2/1  read data beat
- rvalid output 1; rready input 1  R handshake

## Operation
- Reset: every output is 0; the FSMs enter their IDLE states. Memory contents are not cleared.
- Storage: word index = addr[log2(DEPTH)+2:3]. Upper bits are ignored, so addresses wrap modulo DEPTH*8 bytes. Only INCR bursts are supported.
- Beat address: next = addr + (1 << size). A narrow beat writes only the lanes enabled by wstrb. Reads always return the full 64-bit word.
- Write FSM has three states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, latch id, addr, len and size, clear the beat counter, and go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the strobed bytes and increments addr and the counter. On the beat where counter==len, go to W_RESP.
  - W_DATA error flag: set when wlast disagrees with (counter==len), or when wid differs from the latched id.
  - W_RESP: bvalid=1, bid = latched id, bresp = 2'b10 (SLVERR) if the error flag is set, otherwise 2'b00. On bready, go to W_IDLE.
- Read FSM has three states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE: arready=1. On a handshake, latch the fields and go to R_FETCH.
  - R_FETCH: one cycle to register the mem[index] read into rdata. Go to R_DATA.
  - R_DATA: rvalid=1, rid = latched id, rresp=00, rlast = (counter==len).
  - R_DATA on rvalid&rready: if not last, advance addr and register the next word in the same edge, so rvalid stays high. If last, go to R_IDLE.
  - While rready=0, rdata, rlast and rid hold stable.
- Concurrency: the read and write FSMs are independent. Each handles one outstanding burst; a new AW/AR is not accepted until the previous burst completes.
- Same-word read/write at the same edge: the read registers the pre-write data (old data); the write still commits.

## Timing
- AW handshake at edge N → wready=1 from cycle N+1. W beats are accepted back-to-back, one per cycle.
- Last W beat at edge M → bvalid=1 in cycle M+1. bready already high at M+1 → handshake at edge M+1, awready=1 in cycle M+2.
- AR handshake at edge N → rvalid=1 in cycle N+2, with one fetch bubble. With rready held high, beats stream with no gaps: a len+1 beat burst ends with rlast at cycle N+2+len.
- After the final R handshake, arready=1 in the next cycle.
- Reset asserted mid-burst: at the next edge all valid/ready outputs drop to 0 and the in-flight burst is discarded without a B or R response. Any beats already written remain in memory.
- After reset deasserts, awready and arready are 1 in the first cycle.

## Test plan
- Single beat: write awaddr=0x100, len=0, size=3, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF; then read 0x100 → rdata=0xDEADBEEF_CAFEF00D, rlast=1, rresp=00; bresp=00 with bid=awid.
- Burst: 16-beat write at 0x1000 with data=beat index; 16-beat read with rready toggling every other cycle → data 0..15 in order, rlast only on beat 15, payload stable while stalled.
- Narrow/strobe: preload 0x0 to 0x8, then a size=2 write of 0xAABBCCDD at 0x8+4 with wstrb=0xF0 → readback 0xAABBCCDD_00000000.
- Protocol error: len=3 with wlast asserted on beat 1 → bresp=2'b10; len=3 with wlast only on beat 3 → bresp=00.
- Wrap and collision: with DEPTH=1024, a write to 0x2000 reads back at 0x0. A simultaneous same-word read and write → R returns the old data, and a later read returns the new data.
- Reset mid-burst: assert reset during beat 2 of an 8-beat read → rvalid=0 next cycle, arready=1 after release, and earlier written data intact.

Source files
------------

// File: rtl/dma_axi_slave_mem_if.sv
// AXI3 64-bit channel-0 bundle between the DMA controller master port and the slave memory.
interface dma_axi_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [1:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [1:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/dma_axi_slave_mem.sv
// AXI3 INCR-burst slave memory with independent single-outstanding read and write engines.
module dma_axi_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_axi_slave_mem_if.slave    bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [63:0] mem [DEPTH];

  wstate_t           w_state, w_next;
  rstate_t           r_state, r_next;
  logic [ID_W-1:0]   w_id, r_id;
  logic [ADDR_W-1:0] w_addr, r_addr, r_addr_nxt;
  logic [3:0]        w_len, w_cnt, r_len, r_cnt;
  logic [1:0]        w_size, r_size;
  logic              w_err;
  logic [63:0]       r_data;
  logic              aw_hs, w_hs, ar_hs, r_hs;
  logic              w_last_beat, r_last_beat;

  // Ready outputs are held low while reset is asserted, so handshakes are qualified the same way
  assign aw_hs       = bus.awvalid & (w_state == W_IDLE) & ~reset;
  assign w_hs        = bus.wvalid  & (w_state == W_DATA) & ~reset;
  assign ar_hs       = bus.arvalid & (r_state == R_IDLE) & ~reset;
  assign r_hs        = bus.rready  & (r_state == R_DATA);
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);
  assign r_addr_nxt  = r_addr + (ADDR_W'(1) << r_size);

  assign bus.bid   = w_id;
  assign bus.rid   = r_id;
  assign bus.rdata = r_data;
  assign bus.rresp = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next      = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    unique case (w_state)
      W_IDLE: begin
        bus.awready = ~reset;
        if (aw_hs) w_next = W_DATA;
      end
      W_DATA: begin
        bus.wready = 1'b1;
        if (w_hs && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        bus.bresp  = w_err ? 2'b10 : 2'b00;
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next      = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        bus.arready = ~reset;
        if (ar_hs) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        bus.rvalid = 1'b1;
        bus.rlast  = r_last_beat;
        if (r_hs && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // A burst is flagged bad if wlast is misplaced or a beat carries a foreign id
  always_ff @(posedge clk) begin
    if (reset) begin
      w_id   <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_size <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_id   <= bus.awid;
      w_addr <= bus.awaddr;
      w_len  <= bus.awlen;
      w_size <= bus.awsize;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + (ADDR_W'(1) << w_size);
      w_cnt  <= w_cnt + 4'd1;
      if ((bus.wlast != w_last_beat) || (bus.wid != w_id)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.wstrb[i]) mem[w_addr[IDX_W+2:3]][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // The next word is fetched on the accepting edge so a streaming burst has no gaps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      if (ar_hs) begin
        r_id   <= bus.arid;
        r_addr <= bus.araddr;
        r_len  <= bus.arlen;
        r_size <= bus.arsize;
        r_cnt  <= '0;
      end
      if (r_state == R_FETCH) begin
        r_data <= mem[r_addr[IDX_W+2:3]];
      end else if (r_hs && !r_last_beat) begin
        r_addr <= r_addr_nxt;
        r_cnt  <= r_cnt + 4'd1;
        r_data <= mem[r_addr_nxt[IDX_W+2:3]];
      end
    end
  end
endmodule

// File: tb/tb_dma_axi_slave_mem.sv
// Self-checking bench for dma_axi_slave_mem against a byte-level reference memory.
module tb_dma_axi_slave_mem;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dma_axi_slave_mem_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  dma_axi_slave_mem #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] ref_mem   [DEPTH];
  logic [7:0]  ref_known [DEPTH];

  logic [63:0] wq_data [16];
  logic [7:0]  wq_strb [16];

  logic [63:0] rq_data [16];
  logic        rq_last [16];
  logic [3:0]  rq_id   [16];
  logic [1:0]  rq_resp [16];
  int          rd_stall_err, rd_first_lat, rd_span;

  function automatic int widx(input logic [31:0] a);
    return int'(a[31:3]) % DEPTH;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int k;
    k = widx(a);
    for (int i = 0; i < 8; i++) begin
      if (s[i]) begin
        ref_mem[k][8*i +: 8] = d[8*i +: 8];
        ref_known[k][i]      = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] ref_mask(input int k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = ref_known[k][i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] size, input int wlast_beat, input int badid_beat,
                           output logic [1:0] resp, output logic [3:0] rbid,
                           output bit b_prompt, output bit tmo);
    int n;
    logic [31:0] a;
    tmo = 0; resp = 2'b11; rbid = '0; b_prompt = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.awready) begin tmo = 1; bus.awvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = wq_data[b];
      bus.wstrb  = wq_strb[b];
      bus.wlast  = (b == wlast_beat);
      bus.wid    = (b == badid_beat) ? ~id : id;
      n = 0;
      while (!bus.wready && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.wready) begin tmo = 1; bus.wvalid = 1'b0; return; end
      @(posedge clk); #1;
      ref_write(a, wq_data[b], wq_strb[b]);
      a = a + (32'd1 << size);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    b_prompt   = bus.bvalid;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.bvalid) begin tmo = 1; bus.bready = 1'b0; return; end
    resp = bus.bresp;
    rbid = bus.bid;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] size, input bit toggle, output bit tmo);
    int n, beat, cyc, first, last_cyc;
    bit stalled;
    logic [63:0] h_data;
    logic        h_last;
    logic [3:0]  h_id;
    tmo = 0; rd_stall_err = 0; rd_first_lat = -1; rd_span = -1;
    h_data = '0; h_last = 1'b0; h_id = '0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.arready) begin tmo = 1; bus.arvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    beat = 0; cyc = 0; first = -1; last_cyc = -1; stalled = 0;
    while (beat <= int'(len) && cyc < 200) begin
      bus.rready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (bus.rvalid) begin
        if (first < 0) first = cyc;
        if (stalled && (bus.rdata !== h_data || bus.rlast !== h_last || bus.rid !== h_id))
          rd_stall_err++;
        if (bus.rready) begin
          rq_data[beat] = bus.rdata;
          rq_last[beat] = bus.rlast;
          rq_id[beat]   = bus.rid;
          rq_resp[beat] = bus.rresp;
          beat++;
          stalled  = 0;
          last_cyc = cyc;
        end else begin
          stalled = 1;
          h_data  = bus.rdata;
          h_last  = bus.rlast;
          h_id    = bus.rid;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready   = 1'b0;
    tmo          = (beat <= int'(len));
    rd_first_lat = first;
    rd_span      = last_cyc - first;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshakes got=%b exp=000000",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast});
    end
    vectors++;
    if ({bus.bid, bus.bresp, bus.rid, bus.rresp, bus.rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_payload got bid=%h bresp=%b rid=%h rresp=%b rdata=%h exp all 0",
               bus.bid, bus.bresp, bus.rid, bus.rresp, bus.rdata);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.awready, bus.arready} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL post_reset_ready got=%b exp=11", {bus.awready, bus.arready});
    end
  endtask

  task automatic test_single_beat();
    logic [1:0] resp; logic [3:0] rbid; bit bp, tmo;
    wq_data[0] = 64'hDEADBEEF_CAFEF00D;
    wq_strb[0] = 8'hFF;
    axi_write(4'h5, 32'h100, 4'd0, 2'd3, 0, -1, resp, rbid, bp, tmo);
    vectors++;
    if ({tmo, resp, rbid, bp} !== {1'b0, 2'b00, 4'h5, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL single_write got tmo=%0d bresp=%b bid=%h bprompt=%0d exp 0/00/5/1", tmo, resp, rbid, bp);
    end
    vectors++;
    if (bus.awready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL awready_after_b got=%b exp=1", bus.awready);
    end
    axi_read(4'hA, 32'h100, 4'd0, 2'd3, 1'b0, tmo);
    vectors++;
    if ({tmo, rq_data[0], rq_last[0], rq_resp[0], rq_id[0]} !==
        {1'b0, 64'hDEADBEEF_CAFEF00D, 1'b1, 2'b00, 4'hA}) begin
      miscompares++;
      $display("[TB] FAIL single_read got tmo=%0d data=%h last=%b resp=%b id=%h exp data=deadbeefcafef00d last=1 resp=00 id=a",
               tmo, rq_data[0], rq_last[0], rq_resp[0], rq_id[0]);
    end
    vectors++;
    if (rd_first_lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL read_latency got=%0d exp=1", rd_first_lat);
    end
    vectors++;
    if (bus.arready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL arready_after_r got=%b exp=1", bus.arready);
    end
  endtask

  task automatic test_burst();
    logic [1:0] resp; logic [3:0] rbid; bit bp, tmo;
    for (int b = 0; b < 16; b++) begin
      wq_data[b] = 64'(b);
      wq_strb[b] = 8'hFF;
    end
    axi_write(4'h3, 32'h1000, 4'd15, 2'd3, 15, -1, resp, rbid, bp, tmo);
    vectors++;
    if ({tmo, resp} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL burst_write got tmo=%0d bresp=%b exp 0/00", tmo, resp);
    end
    axi_read(4'h6, 32'h1000, 4'd15, 2'd3, 1'b1, tmo);
    vectors++;
    if ({tmo, rd_stall_err} !== {1'b0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL burst_stall got tmo=%0d unstable_beats=%0d exp 0/0", tmo, rd_stall_err);
    end
    for (int b = 0; b < 16; b++) begin
      vectors++;
      if ({rq_data[b], rq_last[b]} !== {64'(b), (b == 15)}) begin
        miscompares++;
        $display("[TB] FAIL burst_beat%0d got data=%h last=%b exp data=%h last=%b",
                 b, rq_data[b], rq_last[b], 64'(b), (b == 15));
      end
    end
  endtask

  task automatic test_narrow();
    logic [1:0] resp; logic [3:0] rbid; bit bp, tmo;
    wq_data[0] = '0; wq_data[1] = '0;
    wq_strb[0] = 8'hFF; wq_strb[1] = 8'hFF;
    axi_write(4'h1, 32'h0, 4'd1, 2'd3, 1, -1, resp, rbid, bp, tmo);
    wq_data[0] = 64'hAABBCCDD_11223344;
    wq_strb[0] = 8'hF0;
    axi_write(4'h1, 32'hC, 4'd0, 2'd2, 0, -1, resp, rbid, bp, tmo);
    axi_read(4'h2, 32'h8, 4'd0, 2'd3, 1'b0, tmo);
    vectors++;
    if ({tmo, rq_data[0]} !== {1'b0, 64'hAABBCCDD_00000000}) begin
      miscompares++;
      $display("[TB] FAIL narrow_strobe got tmo=%0d data=%h exp data=aabbccdd00000000", tmo, rq_data[0]);
    end
  endtask

  task automatic test_protocol_error();
    logic [1:0] resp; logic [3:0] rbid; bit bp, tmo;
    for (int b = 0; b < 4; b++) begin
      wq_data[b] = {$urandom, $urandom};
      wq_strb[b] = 8'hFF;
    end
    axi_write(4'h7, 32'h200, 4'd3, 2'd3, 1, -1, resp, rbid, bp, tmo);
    vectors++;
    if ({tmo, resp} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL early_wlast got tmo=%0d bresp=%b exp 0/10", tmo, resp);
    end
    axi_write(4'h7, 32'h200, 4'd3, 2'd3, 3, -1, resp, rbid, bp, tmo);
    vectors++;
    if ({tmo, resp} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL correct_wlast got tmo=%0d bresp=%b exp 0/00", tmo, resp);
    end
    axi_write(4'h9, 32'h200, 4'd3, 2'd3, 3, 2, resp, rbid, bp, tmo);
    vectors++;
    if ({tmo, resp, rbid} !== {1'b0, 2'b10, 4'h9}) begin
      miscompares++;
      $display("[TB] FAIL wid_mismatch got tmo=%0d bresp=%b bid=%h exp 0/10/9", tmo, resp, rbid);
    end
  endtask

  task automatic test_wrap_collision();
    logic [1:0] resp, resp2; logic [3:0] rbid, rbid2; bit bp, bp2, tmo, tmo2;
    logic [63:0] v_wrap, v_old, v_new;
    v_wrap = {$urandom, $urandom};
    wq_data[0] = v_wrap; wq_strb[0] = 8'hFF;
    axi_write(4'h4, 32'h2000, 4'd0, 2'd3, 0, -1, resp, rbid, bp, tmo);
    axi_read(4'h4, 32'h0, 4'd0, 2'd3, 1'b0, tmo);
    vectors++;
    if ({tmo, rq_data[0]} !== {1'b0, v_wrap}) begin
      miscompares++;
      $display("[TB] FAIL wrap_read got tmo=%0d data=%h exp %h", tmo, rq_data[0], v_wrap);
    end
    v_old = {$urandom, $urandom};
    v_new = ~v_old;
    wq_data[0] = v_old;
    axi_write(4'h4, 32'h3000, 4'd0, 2'd3, 0, -1, resp, rbid, bp, tmo);
    wq_data[0] = v_new;
    fork
      axi_write(4'h4, 32'h3000, 4'd0, 2'd3, 0, -1, resp2, rbid2, bp2, tmo2);
      axi_read(4'h8, 32'h3000, 4'd0, 2'd3, 1'b0, tmo);
    join
    vectors++;
    if ({tmo, tmo2, rq_data[0]} !== {2'b00, v_old}) begin
      miscompares++;
      $display("[TB] FAIL collision_old got tmo=%0d/%0d data=%h exp %h", tmo, tmo2, rq_data[0], v_old);
    end
    axi_read(4'h8, 32'h3000, 4'd0, 2'd3, 1'b0, tmo);
    vectors++;
    if ({tmo, rq_data[0]} !== {1'b0, v_new}) begin
      miscompares++;
      $display("[TB] FAIL collision_new got tmo=%0d data=%h exp %h", tmo, rq_data[0], v_new);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; logic [3:0] rbid; bit bp, tmo, fired;
    int n, hs;
    for (int b = 0; b < 8; b++) begin
      wq_data[b] = {$urandom, $urandom};
      wq_strb[b] = 8'hFF;
    end
    axi_write(4'h2, 32'h400, 4'd7, 2'd3, 7, -1, resp, rbid, bp, tmo);
    bus.arid = 4'h2; bus.araddr = 32'h400; bus.arlen = 4'd7; bus.arsize = 2'd3; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    hs = 0; n = 0; fired = 0;
    while (!fired && n < 50) begin
      if (bus.rvalid && hs == 2) begin
        reset = 1'b1;
        fired = 1;
      end else if (bus.rvalid) begin
        hs++;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.rready = 1'b0;
    vectors++;
    if ({fired, bus.rvalid, bus.arready} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_burst got reached=%0d rvalid=%b arready=%b exp 1/0/0", fired, bus.rvalid, bus.arready);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.arready, bus.rvalid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL release_ready got arready=%b rvalid=%b exp 1/0", bus.arready, bus.rvalid);
    end
    axi_read(4'h2, 32'h400, 4'd7, 2'd3, 1'b0, tmo);
    for (int b = 0; b < 8; b++) begin
      vectors++;
      if ({tmo, rq_data[b]} !== {1'b0, wq_data[b]}) begin
        miscompares++;
        $display("[TB] FAIL retained_beat%0d got tmo=%0d data=%h exp %h", b, tmo, rq_data[b], wq_data[b]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, size; logic [3:0] rbid, len, id; bit bp, tmo, toggle;
    logic [31:0] addr, a;
    logic [63:0] m;
    int k;
    for (int it = 0; it < 25; it++) begin
      size = 2'($urandom_range(0, 3));
      len  = 4'($urandom_range(0, 15));
      id   = 4'($urandom);
      addr = $urandom_range(0, 32'hFFFF) & ~((32'd1 << size) - 32'd1);
      toggle = 1'($urandom);
      for (int b = 0; b < 16; b++) begin
        wq_data[b] = {$urandom, $urandom};
        wq_strb[b] = 8'($urandom_range(1, 255));
      end
      axi_write(id, addr, len, size, int'(len), -1, resp, rbid, bp, tmo);
      vectors++;
      if ({tmo, resp, rbid} !== {1'b0, 2'b00, id}) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_write got tmo=%0d bresp=%b bid=%h exp 0/00/%h", it, tmo, resp, rbid, id);
      end
      axi_read(~id, addr, len, size, toggle, tmo);
      vectors++;
      if ({tmo, rd_stall_err} !== {1'b0, 32'd0} || (!toggle && rd_span !== int'(len))) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_stream got tmo=%0d unstable=%0d span=%0d exp 0/0/%0d", it, tmo, rd_stall_err, rd_span, len);
      end
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
        k = widx(a);
        m = ref_mask(k);
        vectors++;
        if ((rq_data[b] & m) !== (ref_mem[k] & m) || rq_last[b] !== (b == int'(len)) || rq_id[b] !== ~id) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_beat%0d got data=%h last=%b id=%h exp data=%h (mask %h) last=%b id=%h",
                   it, b, rq_data[b], rq_last[b], rq_id[b], ref_mem[k], m, (b == int'(len)), ~id);
        end
        a = a + (32'd1 << size);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = '0;
    end
    reset = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_single_beat();
    test_burst();
    test_narrow();
    test_protocol_error();
    test_wrap_collision();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
